ram_responder: RTL and testbench

- Backing-memory model on the far side of the cache miss/propagation interface.
- Accepts the cache's outgoing requests (prop_address, prop_read_en, prop_write_en, prop_write_data).
- After a fixed latency, returns one ram_valid pulse with a full block on ram_data.
- Used as the RAM behind the cache in simulation; synthesizable as a small on-chip RAM.

---
 rtl/ram_responder_pkg.sv | 27 ++
 rtl/ram_responder_if.sv | 33 +++
 rtl/ram_array.sv | 44 ++++
 rtl/ram_responder.sv | 203 ++++++++++++++++++++
 tb/tb_ram_responder.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_responder_pkg.sv
// ram_responder_pkg
// Shared definitions for the RAM responder slice: the FSM state type,
// default parameter values and the helper that aligns a word index down to
// the start of its response block.
// No ports (package).
package ram_responder_pkg;

  localparam int DEF_RAM_ADDRESS_BITS = 32;
  localparam int DEF_MEM_ADDRESS_BITS = 10;
  localparam int DEF_DATA_BITS        = 32;
  localparam int DEF_BLOCK_WORDS      = 2;
  localparam int DEF_LATENCY          = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // BLOCK_WORDS is a power of two, so clearing the low bits of the index
  // yields the first word of the enclosing block.
  function automatic int unsigned block_base(input int unsigned idx,
                                             input int unsigned block_words);
    return idx & ~(block_words - 1);
  endfunction

endpackage

// File: rtl/ram_responder_if.sv
// ram_responder_if
// Request/response bundle between the cache miss path and the backing RAM.
// Signals:
//   prop_address, prop_read_en, prop_write_en, prop_write_data : cache -> RAM
//   ram_valid, ram_data[BLOCK_WORDS-1:0], ram_busy             : RAM -> cache
// Modports: master (cache side), slave (RAM responder side).
interface ram_responder_if
  import ram_responder_pkg::*;
#(
  parameter int RAM_ADDRESS_BITS = DEF_RAM_ADDRESS_BITS,
  parameter int DATA_BITS        = DEF_DATA_BITS,
  parameter int BLOCK_WORDS      = DEF_BLOCK_WORDS
);

  logic [RAM_ADDRESS_BITS-1:0] prop_address;
  logic                        prop_read_en;
  logic                        prop_write_en;
  logic [DATA_BITS-1:0]        prop_write_data;
  logic                        ram_valid;
  logic [DATA_BITS-1:0]        ram_data [BLOCK_WORDS-1:0];
  logic                        ram_busy;

  modport master (
    output prop_address, prop_read_en, prop_write_en, prop_write_data,
    input  ram_valid, ram_data, ram_busy
  );

  modport slave (
    input  prop_address, prop_read_en, prop_write_en, prop_write_data,
    output ram_valid, ram_data, ram_busy
  );

endinterface

// File: rtl/ram_array.sv
// ram_array
// Storage of 2**MEM_ADDRESS_BITS words of DATA_BITS each, with one
// synchronous write port and a combinational read port returning
// BLOCK_WORDS consecutive words starting at rd_base (wrapping at the top).
// Ports:
//   clk      : clock, rising edge
//   wr_en    : write enable
//   wr_addr  : write word index
//   wr_data  : write word
//   rd_base  : first word index of the block to read
//   rd_block : rd_block[i] = mem[rd_base + i]
module ram_array
  import ram_responder_pkg::*;
#(
  parameter int MEM_ADDRESS_BITS = DEF_MEM_ADDRESS_BITS,
  parameter int DATA_BITS        = DEF_DATA_BITS,
  parameter int BLOCK_WORDS      = DEF_BLOCK_WORDS
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [MEM_ADDRESS_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0]        wr_data,
  input  logic [MEM_ADDRESS_BITS-1:0] rd_base,
  output logic [DATA_BITS-1:0]        rd_block [BLOCK_WORDS-1:0]
);

  localparam int DEPTH = 1 << MEM_ADDRESS_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];

  // Contents are deliberately not reset so data survives a controller reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Index arithmetic stays MEM_ADDRESS_BITS wide so a block that runs off
  // the top of the array wraps back to word 0.
  for (genvar i = 0; i < BLOCK_WORDS; i++) begin : g_rd
    assign rd_block[i] = mem[rd_base + MEM_ADDRESS_BITS'(i)];
  end

endmodule

// File: rtl/ram_responder.sv
// ram_responder
// Backing-memory model behind the cache: accepts one read or write request
// while idle, waits LATENCY cycles, then pulses ram_valid for one cycle with
// the block containing the requested word on ram_data.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : ram_responder_if.slave (request strobes in, response out)
//   stat_reads / stat_writes / stat_drops : 16-bit saturating counters,
//     present only when RAM_RESPONDER_STATS_EN is defined
// Optional feature macro: RAM_RESPONDER_STATS_EN
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int RAM_ADDRESS_BITS = DEF_RAM_ADDRESS_BITS,
  parameter int MEM_ADDRESS_BITS = DEF_MEM_ADDRESS_BITS,
  parameter int DATA_BITS        = DEF_DATA_BITS,
  parameter int BLOCK_WORDS      = DEF_BLOCK_WORDS,
  parameter int LATENCY          = DEF_LATENCY
) (
  input  logic           clk,
  input  logic           reset,
  ram_responder_if.slave bus
`ifdef RAM_RESPONDER_STATS_EN
  ,
  output logic [15:0]    stat_reads,
  output logic [15:0]    stat_writes,
  output logic [15:0]    stat_drops
`endif
);

  localparam int MW       = MEM_ADDRESS_BITS;
  localparam int CNT_BITS = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e               state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [MW-1:0]        idx_q, idx_d;
  logic                 ram_valid_q, ram_valid_d;
  logic [DATA_BITS-1:0] ram_data_q [BLOCK_WORDS-1:0];
  logic [DATA_BITS-1:0] ram_data_d [BLOCK_WORDS-1:0];
  logic [DATA_BITS-1:0] rd_block   [BLOCK_WORDS-1:0];

  logic [MW-1:0] req_idx;
  logic [MW-1:0] sel_idx;
  logic [MW-1:0] rd_base;
  logic          strobe;
  logic          accept;
  logic          mem_we;
  logic          unused_addr_hi;

  assign req_idx        = bus.prop_address[MW-1:0];
  assign unused_addr_hi = ^bus.prop_address[RAM_ADDRESS_BITS-1:MW];
  assign strobe         = bus.prop_read_en | bus.prop_write_en;

  // Acceptance and write enable are set only through if-statements so an
  // unknown strobe falls through to "not accepted" instead of propagating X.
  // A write is never committed on a reset edge.
  always_comb begin
    accept = 1'b0;
    mem_we = 1'b0;
    if (!reset && state_q == IDLE && strobe) begin
      accept = 1'b1;
      if (bus.prop_write_en) begin
        mem_we = 1'b1;
      end
    end
  end

  // In IDLE the block read targets the incoming request (needed when
  // LATENCY is 1); otherwise it targets the latched index.
  assign sel_idx = (state_q == IDLE) ? req_idx : idx_q;
  assign rd_base = MW'(block_base(32'(sel_idx), BLOCK_WORDS));

  ram_array #(
    .MEM_ADDRESS_BITS(MEM_ADDRESS_BITS),
    .DATA_BITS       (DATA_BITS),
    .BLOCK_WORDS     (BLOCK_WORDS)
  ) u_ram_array (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (req_idx),
    .wr_data (bus.prop_write_data),
    .rd_base (rd_base),
    .rd_block(rd_block)
  );

  // Next-state logic for the IDLE -> WAIT -> RESP -> IDLE sequence. The
  // block is captured on the edge entering RESP; with LATENCY of 1 that is
  // the same edge as the write, so the new word is forwarded to keep the
  // response write-first.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    ram_valid_d = 1'b0;
    ram_data_d  = ram_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d = req_idx;
          cnt_d = CNT_BITS'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d     = RESP;
            ram_valid_d = 1'b1;
            for (int i = 0; i < BLOCK_WORDS; i++) begin
              if (mem_we && (rd_base + MW'(i)) == req_idx) begin
                ram_data_d[i] = bus.prop_write_data;
              end else begin
                ram_data_d[i] = rd_block[i];
              end
            end
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          ram_valid_d = 1'b1;
          ram_data_d  = rd_block;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM, counter, latched index and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      ram_valid_q <= 1'b0;
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        ram_data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      ram_valid_q <= ram_valid_d;
      ram_data_q  <= ram_data_d;
    end
  end

  assign bus.ram_valid = ram_valid_q;
  assign bus.ram_data  = ram_data_q;
  assign bus.ram_busy  = (state_q != IDLE);

`ifdef RAM_RESPONDER_STATS_EN
  logic [15:0] stat_reads_q, stat_reads_d;
  logic [15:0] stat_writes_q, stat_writes_d;
  logic [15:0] stat_drops_q, stat_drops_d;
  logic        drop;

  // A drop is any cycle where a strobe is high while a request is still
  // outstanding, including the RESP cycle. All counters stick at 0xFFFF.
  always_comb begin
    drop = 1'b0;
    if (state_q != IDLE && strobe) begin
      drop = 1'b1;
    end
    stat_reads_d  = stat_reads_q;
    stat_writes_d = stat_writes_q;
    stat_drops_d  = stat_drops_q;
    if (accept && !mem_we && stat_reads_q != 16'hFFFF) begin
      stat_reads_d = stat_reads_q + 16'd1;
    end
    if (mem_we && stat_writes_q != 16'hFFFF) begin
      stat_writes_d = stat_writes_q + 16'd1;
    end
    if (drop && stat_drops_q != 16'hFFFF) begin
      stat_drops_d = stat_drops_q + 16'd1;
    end
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
      stat_drops_q  <= '0;
    end else begin
      stat_reads_q  <= stat_reads_d;
      stat_writes_q <= stat_writes_d;
      stat_drops_q  <= stat_drops_d;
    end
  end

  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;
  assign stat_drops  = stat_drops_q;
`endif

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder
// Directed bench for ram_responder with LATENCY=4, MEM_ADDRESS_BITS=10,
// BLOCK_WORDS=2, DATA_BITS=32. Inputs change and outputs are sampled on the
// falling clock edge. Stats checks are compiled in with RAM_RESPONDER_STATS_EN.
module tb_ram_responder;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

`ifdef RAM_RESPONDER_STATS_EN
  logic [15:0] stat_reads;
  logic [15:0] stat_writes;
  logic [15:0] stat_drops;
`endif

  ram_responder_if #(
    .RAM_ADDRESS_BITS(32),
    .DATA_BITS       (32),
    .BLOCK_WORDS     (2)
  ) bus ();

  ram_responder #(
    .RAM_ADDRESS_BITS(32),
    .MEM_ADDRESS_BITS(10),
    .DATA_BITS       (32),
    .BLOCK_WORDS     (2),
    .LATENCY         (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef RAM_RESPONDER_STATS_EN
    ,
    .stat_reads (stat_reads),
    .stat_writes(stat_writes),
    .stat_drops (stat_drops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One request: strobes high for a single rising edge, then wait (bounded)
  // for the response. lat is the number of falling edges after the
  // acceptance edge until ram_valid is seen, or -1 on timeout. busy_after is
  // ram_busy just after acceptance.
  task automatic applyStimulus(input logic [31:0] addr, input logic rd,
                               input logic wr, input logic [31:0] data,
                               output int lat, output logic busy_after);
    @(negedge clk);
    bus.prop_address    = addr;
    bus.prop_read_en    = rd;
    bus.prop_write_en   = wr;
    bus.prop_write_data = data;
    @(negedge clk);
    bus.prop_read_en  = 1'b0;
    bus.prop_write_en = 1'b0;
    busy_after = bus.ram_busy;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.ram_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.ram_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid: got %b expected 0", bus.ram_valid);
    end
    checks++;
    if (bus.ram_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy: got %b expected 0", bus.ram_busy);
    end
    checks++;
    if (bus.ram_data[0] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_data0: got %h expected 0", bus.ram_data[0]);
    end
    checks++;
    if (bus.ram_data[1] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_data1: got %h expected 0", bus.ram_data[1]);
    end
    reset = 1'b0;
  endtask

  task automatic test_first_read();
    int   lat;
    logic busy;
    // Memory is not reset; give words 0, 1 and 11 known values first.
    applyStimulus(32'd0, 1'b0, 1'b1, 32'h0, lat, busy);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("[TB] FAIL first_write_latency: got %0d expected 4", lat);
    end
    applyStimulus(32'd1, 1'b0, 1'b1, 32'h0, lat, busy);
    applyStimulus(32'd11, 1'b0, 1'b1, 32'h0, lat, busy);
    applyStimulus(32'd0, 1'b1, 1'b0, 32'h0, lat, busy);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("[TB] FAIL read_latency: got %0d expected 4", lat);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_after_accept: got %b expected 1", busy);
    end
    checks++;
    if (bus.ram_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_in_resp: got %b expected 1", bus.ram_busy);
    end
    checks++;
    if (bus.ram_data[0] !== 32'h0 || bus.ram_data[1] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL read0_data: got %h,%h expected 0,0",
               bus.ram_data[0], bus.ram_data[1]);
    end
    @(negedge clk);
    checks++;
    if (bus.ram_valid !== 1'b0 || bus.ram_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_resp: got valid=%b busy=%b expected 0,0",
               bus.ram_valid, bus.ram_busy);
    end
  endtask

  task automatic test_write_read();
    int   lat;
    logic busy;
    applyStimulus(32'd10, 1'b0, 1'b1, 32'h55, lat, busy);
    checks++;
    if (lat != 4 || bus.ram_data[0] !== 32'h55 || bus.ram_data[1] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL write10_resp: got lat=%0d %h,%h expected 4 55,0",
               lat, bus.ram_data[0], bus.ram_data[1]);
    end
    applyStimulus(32'd11, 1'b1, 1'b0, 32'h0, lat, busy);
    checks++;
    if (bus.ram_data[0] !== 32'h55) begin
      errors++;
      $display("[TB] FAIL read11_word0: got %h expected 55", bus.ram_data[0]);
    end
    checks++;
    if (bus.ram_data[1] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL read11_word1: got %h expected 0", bus.ram_data[1]);
    end
  endtask

  task automatic test_alias();
    int   lat;
    logic busy;
    applyStimulus(32'h5001, 1'b0, 1'b1, 32'hFAFA, lat, busy);
    checks++;
    if (bus.ram_data[0] !== 32'h0 || bus.ram_data[1] !== 32'hFAFA) begin
      errors++;
      $display("[TB] FAIL alias_write_resp: got %h,%h expected 0,fafa",
               bus.ram_data[0], bus.ram_data[1]);
    end
    applyStimulus(32'd0, 1'b1, 1'b0, 32'h0, lat, busy);
    checks++;
    if (bus.ram_data[1] !== 32'hFAFA) begin
      errors++;
      $display("[TB] FAIL alias_read: got %h expected fafa", bus.ram_data[1]);
    end
  endtask

  task automatic test_both_strobes();
    int   lat;
    logic busy;
    applyStimulus(32'd20, 1'b1, 1'b1, 32'hAB, lat, busy);
    checks++;
    if (lat != 4 || bus.ram_data[0] !== 32'hAB) begin
      errors++;
      $display("[TB] FAIL both_strobes: got lat=%0d data0=%h expected 4 ab",
               lat, bus.ram_data[0]);
    end
    // A read-only request must leave memory alone despite write data.
    applyStimulus(32'd20, 1'b1, 1'b0, 32'h77, lat, busy);
    checks++;
    if (bus.ram_data[0] !== 32'hAB) begin
      errors++;
      $display("[TB] FAIL read_no_write: got %h expected ab", bus.ram_data[0]);
    end
  endtask

  task automatic test_drop();
    int   lat;
    int   nvalid;
    logic busy;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus.prop_address = 32'd10;
    bus.prop_read_en = 1'b1;
    @(negedge clk);
    bus.prop_read_en = 1'b0;
    nvalid = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (bus.ram_valid === 1'b1) nvalid++;
      if (k == 2) begin
        bus.prop_address    = 32'd10;
        bus.prop_read_en    = 1'b1;
        bus.prop_write_en   = 1'b1;
        bus.prop_write_data = 32'h99;
      end
      if (k == 3) begin
        bus.prop_read_en  = 1'b0;
        bus.prop_write_en = 1'b0;
      end
    end
    checks++;
    if (nvalid != 1) begin
      errors++;
      $display("[TB] FAIL drop_valid_count: got %0d expected 1", nvalid);
    end
    checks++;
    if (bus.ram_data[0] !== 32'h55) begin
      errors++;
      $display("[TB] FAIL drop_resp_data: got %h expected 55", bus.ram_data[0]);
    end
`ifdef RAM_RESPONDER_STATS_EN
    checks++;
    if (stat_reads !== 16'd1 || stat_writes !== 16'd0 || stat_drops !== 16'd1) begin
      errors++;
      $display("[TB] FAIL drop_stats: got r=%0d w=%0d d=%0d expected 1 0 1",
               stat_reads, stat_writes, stat_drops);
    end
`endif
    applyStimulus(32'd10, 1'b1, 1'b0, 32'h0, lat, busy);
    checks++;
    if (bus.ram_data[0] !== 32'h55) begin
      errors++;
      $display("[TB] FAIL dropped_write_effect: got %h expected 55",
               bus.ram_data[0]);
    end
  endtask

  task automatic test_reset_mid();
    int   lat;
    int   nvalid;
    logic busy;
    @(negedge clk);
    bus.prop_address = 32'd10;
    bus.prop_read_en = 1'b1;
    @(negedge clk);
    bus.prop_read_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.ram_busy !== 1'b0 || bus.ram_data[0] !== 32'h0 || bus.ram_data[1] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_state: got busy=%b %h,%h expected 0 0,0",
               bus.ram_busy, bus.ram_data[0], bus.ram_data[1]);
    end
    nvalid = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.ram_valid === 1'b1) nvalid++;
    end
    checks++;
    if (nvalid != 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_valid: got %0d pulses expected 0", nvalid);
    end
    applyStimulus(32'd10, 1'b1, 1'b0, 32'h0, lat, busy);
    checks++;
    if (lat != 4 || bus.ram_data[0] !== 32'h55) begin
      errors++;
      $display("[TB] FAIL reset_mid_reread: got lat=%0d data0=%h expected 4 55",
               lat, bus.ram_data[0]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.prop_address    = '0;
    bus.prop_read_en    = 1'b0;
    bus.prop_write_en   = 1'b0;
    bus.prop_write_data = '0;
    test_reset();
    test_first_read();
    test_write_read();
    test_alias();
    test_both_strobes();
    test_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
